// File: rtl/fnd_bcd_scanner_if.sv
// -----------------------------------------------------------------------------
// fnd_bcd_scanner_if
// Bundles the counter-to-display value path and the FND pin outputs.
//   i_value     : 14-bit binary value to display (counter -> scanner)
//   o_fndSelect : active-low digit enables, bit 0 = ones digit
//   o_fndFont   : active-low segments {dp,g,f,e,d,c,b,a}
// master : the side that supplies the value and observes the pins
// slave  : the scanner itself
// -----------------------------------------------------------------------------
interface fnd_bcd_scanner_if;
    logic [13:0] i_value;
    logic [3:0]  o_fndSelect;
    logic [7:0]  o_fndFont;

    modport master (output i_value, input o_fndSelect, input o_fndFont);
    modport slave  (input i_value, output o_fndSelect, output o_fndFont);
endinterface

// File: rtl/fnd_bcd_scanner.sv
// -----------------------------------------------------------------------------
// fnd_bcd_scanner
// Converts a 14-bit binary value (saturated at 9999) to four BCD digits with a
// free-running 16-cycle double-dabble engine and time-multiplexes the digits
// onto a 4-digit common-anode seven-segment display.
// Ports:
//   i_clk   : system clock, rising edge
//   i_reset : asynchronous active-low reset
//   bus     : slave modport (i_value in, o_fndSelect / o_fndFont out, registered)
// Parameters:
//   SCAN_DIV : clocks per digit slot (>= 2)
//   BLANK_LZ : 1 blanks leading-zero digits (ones digit never blanked)
// -----------------------------------------------------------------------------
module fnd_bcd_scanner #(
    parameter int SCAN_DIV = 100000,
    parameter bit BLANK_LZ = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    fnd_bcd_scanner_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    // Add 3 to every BCD nibble that is 5 or more (pre-shift correction).
    function automatic logic [15:0] add3_fix(input logic [15:0] bcd);
        logic [15:0] res;
        res = bcd;
        for (int n = 0; n < 4; n++) begin
            if (bcd[n*4 +: 4] >= 4'd5) begin
                res[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
            end else begin
                res[n*4 +: 4] = bcd[n*4 +: 4];
            end
        end
        return res;
    endfunction

    // Active-low glyph for one BCD nibble, dp off; invalid codes show a dash.
    function automatic logic [7:0] font_of(input logic [3:0] nib);
        logic [7:0] f;
        case (nib)
            4'd0:    f = 8'hC0;
            4'd1:    f = 8'hF9;
            4'd2:    f = 8'hA4;
            4'd3:    f = 8'hB0;
            4'd4:    f = 8'h99;
            4'd5:    f = 8'h92;
            4'd6:    f = 8'h82;
            4'd7:    f = 8'hF8;
            4'd8:    f = 8'h80;
            4'd9:    f = 8'h90;
            default: f = 8'hBF;
        endcase
        return f;
    endfunction

    state_t         state_r;
    state_t         state_s;
    logic           latch_s;
    logic           shift_s;
    logic           load_s;
    logic [13:0]    bin_r;
    logic [15:0]    bcd_r;
    logic [15:0]    bcd_adj_s;
    logic [3:0]     iter_r;
    logic [15:0]    disp_r;
    logic [CNT_W-1:0] cnt_r;
    logic           tick_s;
    logic [1:0]     idx_r;
    logic [1:0]     idx_s;
    logic [3:0]     nib_s;
    logic           blank_s;
    logic [3:0]     sel_s;
    logic [3:0]     sel_r;
    logic [7:0]     font_r;

    // Conversion FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Conversion FSM next-state logic: IDLE -> 14 x SHIFT -> LOAD -> IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:  state_s = ST_SHIFT;
            ST_SHIFT: begin
                if (iter_r == 4'd13) begin
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_SHIFT;
                end
            end
            ST_LOAD:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Conversion FSM outputs: datapath strobes decoded from the state.
    always_comb begin
        latch_s = 1'b0;
        shift_s = 1'b0;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE:  latch_s = 1'b1;
            ST_SHIFT: shift_s = 1'b1;
            ST_LOAD:  load_s  = 1'b1;
            default:  latch_s = 1'b0;
        endcase
    end

    // Correction step applied to the accumulator before each shift.
    always_comb begin
        bcd_adj_s = add3_fix(bcd_r);
    end

    // Double-dabble datapath: sample/saturate in IDLE, shift {bcd,bin} in SHIFT.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            bin_r  <= 14'd0;
            bcd_r  <= 16'd0;
            iter_r <= 4'd0;
        end else if (latch_s) begin
            bin_r  <= (bus.i_value > 14'd9999) ? 14'd9999 : bus.i_value;
            bcd_r  <= 16'd0;
            iter_r <= 4'd0;
        end else if (shift_s) begin
            {bcd_r, bin_r} <= {bcd_adj_s[14:0], bin_r, 1'b0};
            iter_r         <= iter_r + 4'd1;
        end
    end

    // Display register: holds the last completed conversion.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            disp_r <= 16'd0;
        end else if (load_s) begin
            disp_r <= bcd_r;
        end
    end

    // Scan prescaler: wraps every SCAN_DIV clocks.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt_r <= '0;
        end else if (tick_s) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick_s = (cnt_r == CNT_LAST);

    // Values for the digit slot that starts at the next tick.
    always_comb begin
        idx_s   = idx_r + 2'd1;
        nib_s   = disp_r[3:0];
        blank_s = 1'b0;
        sel_s   = 4'b1111;
        case (idx_s)
            2'd0: begin
                nib_s   = disp_r[3:0];
                blank_s = 1'b0;
                sel_s   = 4'b1110;
            end
            2'd1: begin
                nib_s   = disp_r[7:4];
                blank_s = (disp_r[15:4] == 12'd0);
                sel_s   = 4'b1101;
            end
            2'd2: begin
                nib_s   = disp_r[11:8];
                blank_s = (disp_r[15:8] == 8'd0);
                sel_s   = 4'b1011;
            end
            2'd3: begin
                nib_s   = disp_r[15:12];
                blank_s = (disp_r[15:12] == 4'd0);
                sel_s   = 4'b0111;
            end
            default: begin
                nib_s   = 4'd0;
                blank_s = 1'b0;
                sel_s   = 4'b1111;
            end
        endcase
        if (BLANK_LZ == 1'b0) begin
            blank_s = 1'b0;
        end else begin
            blank_s = blank_s;
        end
    end

    // Digit index and output registers: update only on a scan tick.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            idx_r  <= 2'd3;
            sel_r  <= 4'b1111;
            font_r <= 8'hFF;
        end else if (tick_s) begin
            idx_r  <= idx_s;
            sel_r  <= sel_s;
            font_r <= blank_s ? 8'hFF : font_of(nib_s);
        end
    end

    assign bus.o_fndSelect = sel_r;
    assign bus.o_fndFont   = font_r;

endmodule

// File: tb/tb_fnd_bcd_scanner.sv
// -----------------------------------------------------------------------------
// tb_fnd_bcd_scanner
// Directed bench for fnd_bcd_scanner with SCAN_DIV = 4. Two instances share
// clock, reset and input value: one with leading-zero blanking off, one on.
// Expected digit slots come from a decimal model and flow through queues.
// -----------------------------------------------------------------------------
module tb_fnd_bcd_scanner;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] font;
    } pair_t;

    logic  clk;
    logic  reset_n;
    int    edge_cnt;
    int    checks;
    int    failures;
    pair_t q0[$];
    pair_t q1[$];

    fnd_bcd_scanner_if bus0();
    fnd_bcd_scanner_if bus1();

    fnd_bcd_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut0 (
        .i_clk   (clk),
        .i_reset (reset_n),
        .bus     (bus0)
    );

    fnd_bcd_scanner #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut1 (
        .i_clk   (clk),
        .i_reset (reset_n),
        .bus     (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising edges since the last reset release (edge 1 = first IDLE).
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) edge_cnt <= 0;
        else          edge_cnt <= edge_cnt + 1;
    end

    function automatic logic [7:0] glyph(input int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hBF;
        endcase
    endfunction

    // Decimal model of one digit slot.
    function automatic pair_t model(input int shown, input int idx, input bit blank);
        pair_t r;
        int    p;
        p = 1;
        for (int i = 0; i < idx; i++) p = p * 10;
        r.sel = ~(4'b0001 << idx);
        if (blank && idx > 0 && shown < p) r.font = 8'hFF;
        else                               r.font = glyph((shown / p) % 10);
        return r;
    endfunction

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic goto_edge(input int n);
        int guard;
        guard = 0;
        while (edge_cnt < n && guard < 20000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        cmp($sformatf("edge_%0d", n), 16'(edge_cnt), 16'(n));
    endtask

    task automatic pop_check(input string tag);
        pair_t e0;
        pair_t e1;
        e0 = 'x;
        e1 = 'x;
        if (q0.size() > 0) e0 = q0.pop_front();
        if (q1.size() > 0) e1 = q1.pop_front();
        cmp({tag, "/sel0"},  {12'd0, bus0.o_fndSelect}, {12'd0, e0.sel});
        cmp({tag, "/font0"}, {8'd0, bus0.o_fndFont},    {8'd0, e0.font});
        cmp({tag, "/sel1"},  {12'd0, bus1.o_fndSelect}, {12'd0, e1.sel});
        cmp({tag, "/font1"}, {8'd0, bus1.o_fndFont},    {8'd0, e1.font});
    endtask

    task automatic expect_dark(input string tag);
        q0.push_back({4'b1111, 8'hFF});
        q1.push_back({4'b1111, 8'hFF});
        pop_check(tag);
    endtask

    task automatic expect_slot(input string tag, input int n, input int shown, input int idx);
        q0.push_back(model(shown, idx, 1'b0));
        q1.push_back(model(shown, idx, 1'b1));
        goto_edge(n);
        pop_check(tag);
    endtask

    // Four consecutive slots idx 0..3, starting at an edge where idx 0 loads.
    task automatic four_slots(input string tag, input int first, input int shown);
        for (int i = 0; i < 4; i++) begin
            expect_slot($sformatf("%s_d%0d", tag, i), first + 4 * i, shown, i);
        end
    endtask

    task automatic set_value(input logic [13:0] v);
        bus0.i_value = v;
        bus1.i_value = v;
    endtask

    task automatic check_disp(input string tag, input logic [15:0] exp);
        cmp({tag, "/disp0"}, dut0.disp_r, exp);
        cmp({tag, "/disp1"}, dut1.disp_r, exp);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        set_value(14'd1234);
        #22;
        expect_dark("reset");
        check_disp("reset", 16'h0000);
        reset_n = 1'b1;

        // Startup: dark until edge 4, then the unloaded ones digit.
        goto_edge(3);
        expect_dark("pre_first_tick");
        expect_slot("first_tick", 4, 0, 0);
        goto_edge(15);
        check_disp("before_load", 16'h0000);
        goto_edge(16);
        check_disp("first_load", 16'h1234);
        expect_slot("load_tick_same_edge", 16, 0, 3);
        four_slots("v1234", 20, 1234);

        // Zero.
        set_value(14'd0);
        four_slots("v1234b", 36, 1234);
        check_disp("zero_load", 16'h0000);
        four_slots("v0", 52, 0);

        // Max value.
        set_value(14'd9999);
        four_slots("v0b", 68, 0);
        check_disp("max_load", 16'h9999);
        four_slots("v9999", 84, 9999);

        // Saturation.
        set_value(14'h3FFF);
        goto_edge(112);
        check_disp("sat_load", 16'h9999);
        four_slots("vsat", 116, 9999);

        // Input change during SHIFT is ignored until the next IDLE.
        set_value(14'd5678);
        goto_edge(131);
        set_value(14'd42);
        goto_edge(144);
        check_disp("mid_change_load1", 16'h5678);
        four_slots("v5678", 148, 5678);
        check_disp("mid_change_load2", 16'h0042);
        four_slots("v42", 164, 42);

        // Leading-zero blanking cases.
        set_value(14'd7);
        goto_edge(192);
        check_disp("v7_load", 16'h0007);
        four_slots("v7", 196, 7);
        set_value(14'd100);
        goto_edge(224);
        check_disp("v100_load", 16'h0100);
        four_slots("v100", 228, 100);

        // Asynchronous reset pulse mid-SHIFT, between clock edges.
        goto_edge(245);
        #2;
        reset_n = 1'b0;
        #1;
        expect_dark("async_reset");
        check_disp("async_reset", 16'h0000);
        #2;
        reset_n = 1'b1;
        goto_edge(3);
        expect_dark("restart_pre_tick");
        expect_slot("restart_first_tick", 4, 0, 0);
        goto_edge(15);
        check_disp("restart_before_load", 16'h0000);
        goto_edge(16);
        check_disp("restart_load", 16'h0100);
        expect_slot("restart_load_tick", 16, 0, 3);
        four_slots("restart_v100", 20, 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
